// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
// Shares one BRAM read port among NUM_CLIENTS requesters with round-robin
// fairness. Each issued read pushes the issuing client's index into an
// in-order tag FIFO; the head tag steers the BRAM response back to the
// client that asked for it. Request and response paths are combinational,
// so the arbiter adds no cycles of latency on either side.
// ---------------------------------------------------------------------------
module bram_read_arbiter #(
    parameter int ADDR_WIDTH  = 1,
    parameter int DATA_WIDTH  = 1,
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int TAG_DEPTH   = 2
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [NUM_CLIENTS-1:0]            REQ_VALID,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] REQ_ADDR,
    output logic [NUM_CLIENTS-1:0]            REQ_GNT,
    output logic [DATA_WIDTH-1:0]             RESP_DATA,
    output logic [NUM_CLIENTS-1:0]            RESP_RDY,
    input  logic [NUM_CLIENTS-1:0]            RESP_EN,
    output logic [ADDR_WIDTH-1:0]             BRAM_RD_ADDR,
    output logic                              BRAM_RD_EN,
    input  logic                              BRAM_RD_RDY,
    input  logic [DATA_WIDTH-1:0]             BRAM_DOUT,
    input  logic                              BRAM_DOUT_RDY,
    output logic                              BRAM_DOUT_EN,
    output logic                              ERR
);

    // Pointer and occupancy widths for the tag FIFO.
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    // Round-robin pointer: index of the most recently granted client.
    logic [IDX_WIDTH-1:0] r_last;

    // Tag FIFO storage and bookkeeping.
    logic [IDX_WIDTH-1:0] r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    // Sticky protocol error flag.
    logic r_err;

    // Combinational arbitration results.
    logic                   w_found;
    logic [IDX_WIDTH-1:0]   w_winner;
    logic [NUM_CLIENTS-1:0] w_onehot;
    logic                   w_gnt_en;
    logic [NUM_CLIENTS-1:0] w_gnt;
    logic                   w_xfer;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;

    // Combinational response-side results.
    logic                   w_empty;
    logic                   w_full;
    logic [IDX_WIDTH-1:0]   w_head_tag;
    logic                   w_dout_valid;
    logic [NUM_CLIENTS-1:0] w_resp_rdy;
    logic                   w_pop;
    logic                   w_err_evt;

    // Advance a FIFO pointer, wrapping at TAG_DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(TAG_DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // FIFO status is derived from the registered count only, so a pop in the
    // same cycle never re-opens the grant path combinationally.
    assign w_empty  = (r_count == CNT_W'(0));
    assign w_full   = (r_count == CNT_W'(TAG_DEPTH));
    assign w_gnt_en = BRAM_RD_RDY & ~w_full;

    // Round-robin search: first requester found scanning LAST+1, LAST+2, ... modulo NUM_CLIENTS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_onehot = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!w_found && REQ_VALID[i] &&
                    (i == ((int'(r_last) + k) % NUM_CLIENTS))) begin
                    w_found     = 1'b1;
                    w_winner    = IDX_WIDTH'(i);
                    w_onehot[i] = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Gate the search result with BRAM credit and FIFO space.
    always_comb begin
        w_gnt  = '0;
        w_xfer = 1'b0;
        if (w_gnt_en && w_found) begin
            w_gnt  = w_onehot;
            w_xfer = 1'b1;
        end else begin
            w_gnt  = '0;
            w_xfer = 1'b0;
        end
    end

    // Steer the winning client's address onto the BRAM read port.
    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_onehot[i]) begin
                w_rd_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                w_rd_addr = w_rd_addr;
            end
        end
    end

    assign w_head_tag   = r_tag_mem[r_rd_ptr];
    assign w_dout_valid = BRAM_DOUT_RDY & ~w_empty;

    // Route the head response's ready to the client that issued it.
    always_comb begin
        w_resp_rdy = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_dout_valid && (w_head_tag == IDX_WIDTH'(i))) begin
                w_resp_rdy[i] = 1'b1;
            end else begin
                w_resp_rdy[i] = 1'b0;
            end
        end
    end

    // A consume counts only on the owning client's lane; stray RESP_EN bits
    // and responses with no tag to match are flagged as errors.
    assign w_pop     = |(RESP_EN & w_resp_rdy);
    assign w_err_evt = (BRAM_DOUT_RDY & w_empty) | (|(RESP_EN & ~w_resp_rdy));

    assign REQ_GNT      = w_gnt;
    assign BRAM_RD_EN   = |(REQ_VALID & w_gnt);
    assign BRAM_RD_ADDR = w_rd_addr;
    assign RESP_DATA    = BRAM_DOUT;
    assign RESP_RDY     = w_resp_rdy;
    assign BRAM_DOUT_EN = w_pop;
    assign ERR          = r_err;

    // Tag FIFO write side: record the winner's index on every transfer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_xfer) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
            r_wr_ptr            <= ptr_inc(r_wr_ptr);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Tag FIFO read side: retire the head tag when its response is consumed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count <= '0;
        end else begin
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Round-robin pointer: remember the last winner; reset favours client 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_last <= IDX_WIDTH'(NUM_CLIENTS - 1);
        end else if (w_xfer) begin
            r_last <= w_winner;
        end else begin
            r_last <= r_last;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule
